// File: rtl/pea_pkg.sv
// Shared PEA constants and the divider-share arbiter state type.
package pea_pkg;
    localparam int N_BITS      = 32;
    localparam int N_DIV_STAGE = 8;
    localparam int N_DIV_REQ   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } arb_fsm_t;
endpackage

// File: rtl/div_share_arbiter_if.sv
// Requester-side request/response channels of the shared divider.
interface div_share_arbiter_if #(
    parameter int N_REQ  = pea_pkg::N_DIV_REQ,
    parameter int N_BITS = pea_pkg::N_BITS
);
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][N_BITS-1:0] req_n;
    logic [N_REQ-1:0][N_BITS-1:0] req_d;
    logic [N_REQ-1:0]             rsp_valid;
    logic [N_REQ-1:0]             rsp_ready;
    logic [N_BITS-1:0]            rsp_q;
    logic [N_BITS-1:0]            rsp_r;

    modport master (
        output req_valid, req_n, req_d, rsp_ready,
        input  req_ready, rsp_valid, rsp_q, rsp_r
    );
    modport slave (
        input  req_valid, req_n, req_d, rsp_ready,
        output req_ready, rsp_valid, rsp_q, rsp_r
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr) + i) % N);
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end
endmodule

// File: rtl/div_share_arbiter.sv
// Time-shares one multicycle divider between N_REQ requesters (round robin);
// divide-by-zero is answered locally without touching the divider.
module div_share_arbiter #(
    parameter int N_REQ       = pea_pkg::N_DIV_REQ,
    parameter int N_BITS      = pea_pkg::N_BITS,
    parameter int N_DIV_STAGE = pea_pkg::N_DIV_STAGE
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    div_share_arbiter_if.slave bus,
    output logic              div_en_o,
    output logic [N_BITS-1:0] div_n_o,
    output logic [N_BITS-1:0] div_d_o,
    input  logic [N_BITS-1:0] div_q_i,
    input  logic [N_BITS-1:0] div_r_i,
    input  logic              div_valid_i,
    output logic              busy_o
);
    import pea_pkg::*;

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (N_DIV_STAGE > 1) ? $clog2(N_DIV_STAGE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_DIV_STAGE - 1);

    arb_fsm_t          state, nxt;
    logic [IW-1:0]     rr_ptr, id, g_idx;
    logic [N_REQ-1:0]  g_onehot, req_ready, rsp_valid;
    logic              g_any, div0, en_last, run_done;
    logic [N_BITS-1:0] n_r, d_r, q_r, r_r;
    logic [CW-1:0]     cnt;
    logic              en_done, got;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (g_onehot),
        .idx (g_idx),
        .any (g_any)
    );

    assign div0     = (bus.req_d[g_idx] == '0);
    assign en_last  = !en_done && (cnt == CNT_LAST);
    // Leave RUN only once both the result is in and the enable burst is complete,
    // so the divider's internal counter is back at zero for the next operation.
    assign run_done = (got || div_valid_i) && (en_done || en_last);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt       = state;
        req_ready = '0;
        rsp_valid = '0;
        div_en_o  = 1'b0;
        case (state)
            IDLE: if (g_any && rst_n_i) begin
                req_ready = g_onehot;
                nxt       = div0 ? RESP : RUN;
            end
            RUN: begin
                div_en_o = !en_done;
                if (run_done) nxt = RESP;
            end
            RESP: begin
                rsp_valid[id] = 1'b1;
                if (bus.rsp_ready[id]) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr  <= '0;
            id      <= '0;
            n_r     <= '0;
            d_r     <= '0;
            q_r     <= '0;
            r_r     <= '0;
            cnt     <= '0;
            en_done <= 1'b0;
            got     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (g_any) begin
                    id      <= g_idx;
                    n_r     <= bus.req_n[g_idx];
                    d_r     <= bus.req_d[g_idx];
                    cnt     <= '0;
                    en_done <= 1'b0;
                    got     <= 1'b0;
                    if (div0) begin
                        q_r <= '1;
                        r_r <= bus.req_n[g_idx];
                    end
                end
                RUN: begin
                    if (!en_done) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) en_done <= 1'b1;
                    end
                    if (div_valid_i) begin
                        q_r <= div_q_i;
                        r_r <= div_r_i;
                        got <= 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready[id])
                    rr_ptr <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_q     = q_r;
    assign bus.rsp_r     = r_r;
    assign div_n_o       = n_r;
    assign div_d_o       = d_r;
    assign busy_o        = (state != IDLE);
endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one multicycle restoring divider (r_div) between N_REQ requesters, e.g. the PEs of one PEA row.
- Round-robin arbitration on a valid/ready request channel.
- Latches the winner's operands, sequences the divider enable, captures quotient and remainder, and returns them on a per-requester valid/ready response channel.
- Divide-by-zero is resolved locally without occupying the divider.

Parameters:
N_REQ, 4, number of requesters (>=2)
N_BITS, pea_pkg::N_BITS, operand/result width
N_DIV_STAGE, pea_pkg::N_DIV_STAGE, divider iterations per operation (power of two)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  request valid per requester
req_ready_o  out  N_REQ  one-hot accept pulse to granted requester
req_n_i  in  N_REQ x N_BITS  dividends
req_d_i  in  N_REQ x N_BITS  divisors
rsp_valid_o  out  N_REQ  one-hot result valid
rsp_ready_i  in  N_REQ  result accepted per requester
rsp_q_o  out  N_BITS  quotient (shared bus, qualified by rsp_valid_o)
rsp_r_o  out  N_BITS  remainder (shared bus)
div_en_o  out  1  divider enable
div_n_o  out  N_BITS  latched dividend to divider
div_d_o  out  N_BITS  latched divisor to divider
div_q_i  in  N_BITS  divider quotient
div_r_i  in  N_BITS  divider remainder
div_valid_i  in  1  divider result valid
busy_o  out  1  operation in flight (state != IDLE)

Behaviour:
- Reset: state=IDLE, rr pointer=0, all outputs 0, operand/result/id registers 0.
- The FSM is encoded as typedef arb_fsm_t with states IDLE, RUN, RESP.
- IDLE:
  - If any req_valid_i is high, pick the first set bit at or above the rr pointer, wrapping modulo N_REQ.
  - Assert req_ready_o[g] combinationally in the same cycle; the handshake completes then.
  - Latch req_n_i[g], req_d_i[g] and id=g.
  - If req_d_i[g]==0: load q=all ones, r=n and go to RESP, skipping the divider.
  - Else clear the enable counter and go to RUN.
  - With no request, stay in IDLE.
- RUN:
  - div_en_o=1 for exactly N_DIV_STAGE consecutive cycles, counted by an internal $clog2(N_DIV_STAGE)-bit counter. This leaves the divider's own counter wrapped to 0 for the next operation.
  - div_n_o and div_d_o stay stable throughout.
  - On the cycle div_valid_i=1, capture div_q_i and div_r_i.
  - Go to RESP on the later of capture and counter terminal count.
  - The divider result is therefore available no earlier than N_DIV_STAGE+1 cycles after the accept.
- RESP:
  - rsp_valid_o[id]=1; rsp_q_o and rsp_r_o are held stable until rsp_ready_i[id]=1.
  - On the handshake: rr pointer = (id+1) mod N_REQ, go to IDLE.
  - rsp_ready_i of other requesters is ignored.
- Outside RESP, rsp_valid_o=0; rsp_q_o and rsp_r_o keep their last value.
- Only one operation is in flight at a time; req_ready_o is 0 in RUN and RESP.
- A new request is accepted at the earliest in the cycle after the RESP handshake (the IDLE cycle).
- Simultaneous requests: the rr pointer decides. A requester that just finished has the lowest priority on the next arbitration.
- A requester dropping req_valid_i before it is granted is legal; it is simply not selected.
- Any div_valid_i outside RUN is ignored.
- Reset asserted mid-operation returns everything to reset values immediately (async). The divider is reset by the same rst_n_i.
- Arithmetic is unsigned; no width growth. Divide-by-zero result is q = 2^N_BITS-1, r = n.

Decomposition:
- pea_pkg: arb_fsm_t typedef; N_BITS and N_DIV_STAGE (already present); new constant N_DIV_REQ=4 used as the default for N_REQ.
- One sub-module: rr_arbiter (combinational priority pick from request vector and pointer; outputs one-hot grant and its index), reusable elsewhere in the PEA.
- The FSM, counters and registers stay in div_share_arbiter.

Test Plan:
- Single request, N_BITS=32: req0 n=100 d=7 -> one req_ready_o[0] pulse, div_en_o high for exactly N_DIV_STAGE cycles, then rsp_valid_o[0] with q=14 r=2, held until rsp_ready_i[0].
- Four simultaneous requests: (100/7, 255/16, 9/3, 1/2) at reset -> grants in order 0,1,2,3; results 14r2, 15r15, 3r0, 0r1 each on its own one-hot rsp_valid_o.
- Fairness: requesters 0 and 2 always valid -> grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- Divide-by-zero: req1 n=0x1234 d=0 -> div_en_o stays 0, rsp_valid_o[1] one cycle after accept with q=0xFFFFFFFF r=0x1234.
- Backpressure: rsp_ready_i low for 10 cycles in RESP -> outputs stable, no new req_ready_o while requesters wait; accepted on the IDLE cycle after the handshake. Back-to-back ops on the same requester give correct results (divider counter realigned).
- Reset mid-RUN: drop rst_n_i at cycle 3 of RUN -> all outputs 0 immediately. After release, a request 50/5 returns q=10 r=0.
